// File: rtl/poly_mul_pkg.sv
// Shared definitions for the poly_mul sequencer.
//   - op codes (as sampled on op with start)
//   - sel encodings driven to the datapath
//   - polynomial geometry and twiddle ROM bases
//   - FSM state type
//   - tf_addr(): twiddle ROM address for layer k at word cnt
package poly_mul_pkg;

  localparam logic [1:0] OP_NTT      = 2'b00;
  localparam logic [1:0] OP_INTT     = 2'b01;
  localparam logic [1:0] OP_PWM_MUL  = 2'b10;
  localparam logic [1:0] OP_PWM_ADD  = 2'b11;

  localparam logic [2:0] SEL_IDLE    = 3'b000;
  localparam logic [2:0] SEL_NTT     = 3'b001;
  localparam logic [2:0] SEL_INTT    = 3'b100;
  localparam logic [2:0] SEL_PWM_MUL = 3'b010;
  localparam logic [2:0] SEL_PWM_ADD = 3'b110;

  localparam int N_WORDS  = 32;
  localparam int N_LAYERS = 8;
  localparam int TF1_BASE = 63;
  localparam int TF2_BASE = 127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Layers 0..5 share one twiddle per block of 2^(5-k) words; layers 6 and 7
  // use a distinct twiddle per word. Maximum result is 127 + 31 = 158.
  function automatic logic [7:0] tf_addr(input logic [2:0] k, input logic [4:0] cnt);
    logic [7:0] c8;
    c8 = {3'b000, cnt};
    if (k == 3'd7)
      return 8'(TF2_BASE) + c8;
    else if (k == 3'd6)
      return 8'(TF1_BASE) + c8;
    else
      return (8'd1 << k) + (c8 >> (3'd5 - k));
  endfunction

endpackage

// File: rtl/wr_addr_pipe.sv
// Delay line that turns the read strobe/address into the write strobe/address.
// Ports:
//   clk, rst           clock, asynchronous active-low clear
//   rd_valid, rd_addr  read strobe and word address entering the line
//   tap                delay in cycles (1..MAX_LAT); other values give no output
//   wr_valid, wr_addr  strobe and address delayed by tap cycles
module wr_addr_pipe #(
  parameter int MAX_LAT = 8,
  parameter int AW      = 5,
  parameter int TAP_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_valid,
  input  logic [AW-1:0]    rd_addr,
  input  logic [TAP_W-1:0] tap,
  output logic             wr_valid,
  output logic [AW-1:0]    wr_addr
);

  logic [MAX_LAT-1:0] vld_q;
  logic [AW-1:0]      addr_q [MAX_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < MAX_LAT; i++) addr_q[i] <= '0;
    end else begin
      vld_q     <= {vld_q[MAX_LAT-2:0], rd_valid};
      addr_q[0] <= rd_addr;
      for (int i = 1; i < MAX_LAT; i++) addr_q[i] <= addr_q[i-1];
    end
  end

  // Stage i holds the entry from i+1 cycles ago.
  always_comb begin
    wr_valid = 1'b0;
    wr_addr  = '0;
    for (int i = 0; i < MAX_LAT; i++) begin
      if (i + 1 == int'(tap)) begin
        wr_valid = vld_q[i];
        wr_addr  = addr_q[i];
      end
    end
  end

endmodule

// File: rtl/poly_mul_ctrl.sv
// Sequencer for the 4-butterfly poly_mul datapath: one NTT, INTT, pointwise
// multiply or pointwise add per start pulse.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, op       operation request and code (sampled in IDLE only)
//   busy, done      busy through RUN/DRAIN/DONE; done pulses in DONE
//   sel, ntt_l      datapath mode and layer arrangement
//   tf_address      twiddle ROM address, issued alongside rd_addr
//   rd_en, rd_addr  bank read strobe and word address
//   wr_en, wr_addr  bank write strobe and word address (rd delayed by LAT)
//   bank            0: read A / write B, 1: read B / write A
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; all outputs 0
// ST_RUN   | 32 reads of one layer, cnt = word address
// ST_DRAIN | LAT cycles with no reads while the writes of the layer land
// ST_DONE  | one-cycle done pulse
module poly_mul_ctrl
  import poly_mul_pkg::*;
#(
  parameter int LAT_NTT  = 6,
  parameter int LAT_INTT = 6,
  parameter int LAT_PWM  = 4,
  parameter int MAX_LAT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic [2:0] sel,
  output logic [1:0] ntt_l,
  output logic [7:0] tf_address,
  output logic       rd_en,
  output logic [4:0] rd_addr,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic       bank
);

  localparam int TAP_W = $clog2(MAX_LAT + 1);

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [4:0]       cnt_q;
  logic [2:0]       layer_q;
  logic [TAP_W-1:0] drain_q;
  logic [TAP_W-1:0] lat;
  logic             pwm;
  logic             last_layer;
  logic [2:0]       k;
  logic [2:0]       op_sel;

  assign pwm        = op_q[1];
  assign last_layer = pwm | (layer_q == 3'(N_LAYERS - 1));
  // INTT walks the NTT layers backwards.
  assign k          = (op_q == OP_INTT) ? (3'(N_LAYERS - 1) - layer_q) : layer_q;

  always_comb begin
    lat    = TAP_W'(LAT_PWM);
    op_sel = SEL_PWM_ADD;
    case (op_q)
      OP_NTT:     begin lat = TAP_W'(LAT_NTT);  op_sel = SEL_NTT;     end
      OP_INTT:    begin lat = TAP_W'(LAT_INTT); op_sel = SEL_INTT;    end
      OP_PWM_MUL: begin lat = TAP_W'(LAT_PWM);  op_sel = SEL_PWM_MUL; end
      default:    begin lat = TAP_W'(LAT_PWM);  op_sel = SEL_PWM_ADD; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    done       = 1'b0;
    sel        = SEL_IDLE;
    ntt_l      = 2'd0;
    tf_address = 8'd0;
    rd_en      = 1'b0;
    rd_addr    = 5'd0;
    bank       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        busy  = 1'b1;
        sel   = op_sel;
        bank  = pwm ? 1'b0 : layer_q[0];
        if (pwm || k == 3'd7) ntt_l = 2'd2;
        else if (k == 3'd6)   ntt_l = 2'd1;
        else                  ntt_l = 2'd0;
        if (state_q == ST_RUN) begin
          rd_en      = 1'b1;
          rd_addr    = cnt_q;
          tf_address = pwm ? 8'd0 : tf_addr(k, cnt_q);
          if (cnt_q == 5'(N_WORDS - 1)) state_d = ST_DRAIN;
        end else if (drain_q == '0) begin
          state_d = last_layer ? ST_DONE : ST_RUN;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= 2'd0;
      cnt_q   <= 5'd0;
      layer_q <= 3'd0;
      drain_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            cnt_q   <= 5'd0;
            layer_q <= 3'd0;
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q + 5'd1;
          // Down-counter loaded so that it reaches 0 in the final DRAIN cycle.
          if (cnt_q == 5'(N_WORDS - 1)) drain_q <= lat - TAP_W'(1);
        end
        ST_DRAIN: begin
          if (drain_q != '0)    drain_q <= drain_q - TAP_W'(1);
          else if (!last_layer) layer_q <= layer_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  wr_addr_pipe #(
    .MAX_LAT (MAX_LAT),
    .AW      (5),
    .TAP_W   (TAP_W)
  ) u_wr_addr_pipe (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (rd_en),
    .rd_addr  (rd_addr),
    .tap      (lat),
    .wr_valid (wr_en),
    .wr_addr  (wr_addr)
  );

endmodule

// File: tb/tb_poly_mul_ctrl.sv
module tb_poly_mul_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic       busy, done, rd_en, wr_en, bank;
  logic [2:0] sel;
  logic [1:0] ntt_l;
  logic [7:0] tf_address;
  logic [4:0] rd_addr, wr_addr;

  poly_mul_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .busy       (busy),
    .done       (done),
    .sel        (sel),
    .ntt_l      (ntt_l),
    .tf_address (tf_address),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .bank       (bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int addr; int tf; int sel; int ntt_l; int bnk;
  } rd_exp_t;
  typedef struct { int cyc; int addr; } wr_exp_t;
  typedef struct { int cyc; int tf; int ntt_l; } spot_t;

  rd_exp_t exp_rd[$];
  wr_exp_t exp_wr[$];
  int      exp_done[$];
  spot_t   spots[$];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rd_seen = 0;
  int wr_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected responses for one operation started with start sampled at cycle t0.
  task automatic push_op(input logic [1:0] op_i, input int t0);
    int lat, nl, sel_e, k, t, tf, nl_e, bk;
    bit pwm;
    pwm   = op_i[1];
    lat   = pwm ? 4 : 6;
    nl    = pwm ? 1 : 8;
    case (op_i)
      2'b00:   sel_e = 1;
      2'b01:   sel_e = 4;
      2'b10:   sel_e = 2;
      default: sel_e = 6;
    endcase
    for (int l = 0; l < nl; l++) begin
      k = (op_i == 2'b01) ? 7 - l : l;
      for (int c = 0; c < 32; c++) begin
        t = t0 + 1 + l * (32 + lat) + c;
        if (pwm) begin
          tf = 0; nl_e = 2; bk = 0;
        end else begin
          if (k == 7)      begin tf = 127 + c; nl_e = 2; end
          else if (k == 6) begin tf = 63 + c;  nl_e = 1; end
          else             begin tf = (1 << k) + c / (32 >> k); nl_e = 0; end
          bk = l % 2;
        end
        exp_rd.push_back('{t, c, tf, sel_e, nl_e, bk});
        exp_wr.push_back('{t + lat, c});
      end
    end
    exp_done.push_back(t0 + (pwm ? 37 : 305));
    if (op_i == 2'b00) begin
      spots.push_back('{t0 + 1,   1,   0});
      spots.push_back('{t0 + 120, 9,   0});
      spots.push_back('{t0 + 239, 73,  1});
      spots.push_back('{t0 + 298, 158, 2});
    end else if (op_i == 2'b01) begin
      spots.push_back('{t0 + 1,   127, 2});
      spots.push_back('{t0 + 32,  158, 2});
      spots.push_back('{t0 + 267, 1,   0});
    end
  endtask

  rd_exp_t er;
  wr_exp_t ew;
  spot_t   es;
  int      ed;

  always @(negedge clk) begin
    if (rd_en) begin
      rd_seen++;
      if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
      else begin
        er = exp_rd.pop_front();
        check("rd_cycle", cyc, er.cyc);
        check("rd_addr", int'(rd_addr), er.addr);
        check("tf_address", int'(tf_address), er.tf);
        check("sel", int'(sel), er.sel);
        check("ntt_l", int'(ntt_l), er.ntt_l);
        check("bank", int'(bank), er.bnk);
      end
    end
    if (wr_en) begin
      wr_seen++;
      if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
      else begin
        ew = exp_wr.pop_front();
        check("wr_cycle", cyc, ew.cyc);
        check("wr_addr", int'(wr_addr), ew.addr);
      end
    end
    if (done) begin
      if (exp_done.size() == 0) check("done_unexpected", 1, 0);
      else begin
        ed = exp_done.pop_front();
        check("done_cycle", cyc, ed);
        check("done_bank", int'(bank), 0);
      end
    end
    if (spots.size() != 0 && spots[0].cyc == cyc) begin
      es = spots.pop_front();
      check("spot_tf", int'(tf_address), es.tf);
      check("spot_ntt_l", int'(ntt_l), es.ntt_l);
    end
  end

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_wr_en"}, int'(wr_en), 0);
    check({name, "_rd_en"}, int'(rd_en), 0);
    check({name, "_rest"},
          int'({done, sel, ntt_l, tf_address, rd_addr, wr_addr, bank}), 0);
  endtask

  task automatic run_op(input logic [1:0] op_i, input bit stray, input int rst_at,
                        input int exp_rw);
    int t0;
    bit seen, was_reset;
    seen = 0;
    was_reset = 0;
    @(negedge clk);
    t0 = cyc;
    rd_seen = 0;
    wr_seen = 0;
    push_op(op_i, t0);
    start = 1'b1;
    op    = op_i;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      if (stray) begin
        start = (cyc == t0 + 50);
        op    = 2'b10;
      end
      if (rst_at >= 0 && cyc == t0 + rst_at) begin
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        spots.delete();
        was_reset = 1;
        seen = 1;
      end
    end
    start = 1'b0;
    if (was_reset) begin
      repeat (4) @(negedge clk);
      rst = 1'b1;
    end else begin
      check("done_seen", int'(seen), 1);
      check("rd_count", rd_seen, exp_rw);
    end
    repeat (10) @(negedge clk);
    if (!was_reset) check("wr_count", wr_seen, exp_rw);
    check("left_rd", exp_rd.size(), 0);
    check("left_wr", exp_wr.size(), 0);
    check("left_done", exp_done.size(), 0);
    check("left_spot", spots.size(), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_sel_bank", int'({sel, ntt_l, bank}), 0);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    #3 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_op(2'b00, 1'b1, -1, 256);  // NTT with a start pulse 50 cycles in
    run_op(2'b01, 1'b0, -1, 256);  // INTT
    run_op(2'b11, 1'b0, -1, 32);   // PWM-add
    run_op(2'b10, 1'b0, -1, 32);   // PWM-mult
    run_op(2'b00, 1'b0, 187, 0);   // NTT reset mid-DRAIN of layer 4
    run_op(2'b00, 1'b0, -1, 256);  // full NTT after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
